ex_muldiv: RTL

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 29 ++
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_muldiv_iter.sv | 34 +++
 rtl/ex_muldiv.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and the default operand width.
package ex_muldiv_pkg;

    localparam int unsigned MULDIV_N = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the ID/EX pipeline stage and the multiply/divide unit.
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int N = MULDIV_N
) ();

    logic         start_in;
    logic [1:0]   op_in;
    logic [N-1:0] Read_Data_1_in;
    logic [N-1:0] Read_Data_2_in;
    logic         flush_in;
    logic         busy_out;
    logic         done_out;
    logic [N-1:0] hi_out;
    logic [N-1:0] lo_out;

    modport master (
        output start_in, op_in, Read_Data_1_in, Read_Data_2_in, flush_in,
        input  busy_out, done_out, hi_out, lo_out
    );

    modport slave (
        input  start_in, op_in, Read_Data_1_in, Read_Data_2_in, flush_in,
        output busy_out, done_out, hi_out, lo_out
    );

endinterface

// File: rtl/ex_muldiv_iter.sv
// Combinational single-step datapath: one shift-add multiply step or one
// restoring compare-subtract-shift divide step on a 2N-bit accumulator.
module muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int N = MULDIV_N
) (
    input  logic           div_sel,
    input  logic [2*N-1:0] acc_in,
    input  logic [N-1:0]   opb_in,
    output logic [2*N-1:0] acc_out
);

    logic [N:0] mul_sum;
    logic [N:0] rem_shift;
    logic [N:0] rem_diff;

    // Multiply keeps {partial product, remaining multiplier bits}; divide keeps
    // {remainder, dividend/quotient}. Bit N of rem_diff is the divide borrow.
    always_comb begin
        mul_sum   = {1'b0, acc_in[2*N-1:N]} + (acc_in[0] ? {1'b0, opb_in} : {(N+1){1'b0}});
        rem_shift = acc_in[2*N-1:N-1];
        rem_diff  = rem_shift - {1'b0, opb_in};
        acc_out   = {mul_sum, acc_in[N-1:1]};
        if (div_sel) begin
            if (!rem_diff[N]) begin
                acc_out = {rem_diff[N-1:0], acc_in[N-2:0], 1'b1};
            end else begin
                acc_out = {rem_shift[N-1:0], acc_in[N-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: N cycles of
// magnitude arithmetic followed by one sign-fix cycle that commits HI/LO.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int N = MULDIV_N
) (
    input  logic        clk,
    input  logic        reset_in,
    ex_muldiv_if.slave  bus
);

    localparam int CW = $clog2(N + 1);

    muldiv_state_e  state_q, state_d;
    muldiv_op_e     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   opb_q, opb_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           div0_q, div0_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;

    muldiv_op_e     op_sel;
    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [2*N-1:0] iter_out;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quot, rem;

    muldiv_iter #(.N(N)) u_iter (
        .div_sel (op_is_div(op_q)),
        .acc_in  (acc_q),
        .opb_in  (opb_q),
        .acc_out (iter_out)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        op_sel = muldiv_op_e'(bus.op_in);
        a_neg  = op_is_signed(op_sel) & bus.Read_Data_1_in[N-1];
        b_neg  = op_is_signed(op_sel) & bus.Read_Data_2_in[N-1];
        a_mag  = a_neg ? -bus.Read_Data_1_in : bus.Read_Data_1_in;
        b_mag  = b_neg ? -bus.Read_Data_2_in : bus.Read_Data_2_in;

        prod = neg_res_q ? -acc_q : acc_q;
        quot = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
        rem  = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    op_d      = op_sel;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (bus.Read_Data_2_in == '0);
                    cnt_d     = CW'(N);
                    state_d   = ST_CALC;
                    if (op_is_div(op_sel)) begin
                        acc_d = {{N{1'b0}}, a_mag};
                        opb_d = b_mag;
                    end else begin
                        acc_d = {{N{1'b0}}, b_mag};
                        opb_d = a_mag;
                    end
                end
            end
            ST_CALC: begin
                acc_d = iter_out;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // A zero divisor leaves the dividend magnitude as remainder, so
                // re-signing it restores the dividend as presented.
                if (op_is_div(op_q)) begin
                    lo_d = div0_q ? {N{1'b1}} : quot;
                    hi_d = rem;
                end else begin
                    lo_d = prod[N-1:0];
                    hi_d = prod[2*N-1:N];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.flush_in) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy_out = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign bus.done_out = (state_q == ST_DONE);
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;

endmodule
